// File: rtl/ahb_bm_input_stage_pkg.sv
// Encodings shared by the bus-matrix input stages, decoder and output arbiters.
// Holds AHB HTRANS/HBURST/HRESP values plus a small transfer-type helper.
package ahb_bm_input_stage_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_bm_input_stage.sv
// Master-side input stage: passes the address phase through, or holds it when not granted; zero added latency when granted.
// Backpressure: HREADYOUTS is held low while a transfer sits in the hold bank, otherwise mirrors the routed slave ready.
module ahb_bm_input_stage
  import ahb_bm_input_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int PROT_W = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [PROT_W-1:0] HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic              sel_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [1:0]        trans_out,
  output logic              write_out,
  output logic [2:0]        size_out,
  output logic [2:0]        burst_out,
  output logic [PROT_W-1:0] prot_out,
  output logic              mastlock_out,
  output logic              held_tran,
  input  logic              addr_accept,
  input  logic              dphase_active,
  input  logic              readyout_dec,
  input  logic              resp_dec
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [PROT_W-1:0] prot;
    logic              mastlock;
  } aphase_t;

  logic    pend;
  aphase_t hold;
  aphase_t live;
  aphase_t present;
  logic    new_tran;
  logic    capture;
  logic    rel_tran;

  assign live = '{addr:     HADDRS,
                  trans:    HTRANSS,
                  write:    HWRITES,
                  size:     HSIZES,
                  burst:    HBURSTS,
                  prot:     HPROTS,
                  mastlock: HMASTLOCKS};

  assign new_tran = HSELS & HREADYS & is_active(HTRANSS);
  assign capture  = !pend & new_tran & !addr_accept;
  assign rel_tran = pend & addr_accept;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend <= 1'b0;
      hold <= '0;
    end else if (capture) begin
      pend <= 1'b1;
      hold <= live;
    end else if (rel_tran) begin
      pend <= 1'b0;
    end
  end

  // A held SEQ may have lost its burst context to another master, so reissue it as a fresh INCR.
  always_comb begin
    present = live;
    sel_out = HSELS & HREADYS;
    if (pend) begin
      present = hold;
      sel_out = 1'b1;
      if (hold.trans == TRANS_SEQ) begin
        present.trans = TRANS_NONSEQ;
        present.burst = BURST_INCR;
      end
    end
  end

  assign addr_out     = present.addr;
  assign trans_out    = present.trans;
  assign write_out    = present.write;
  assign size_out     = present.size;
  assign burst_out    = present.burst;
  assign prot_out     = present.prot;
  assign mastlock_out = present.mastlock;
  assign held_tran    = pend;

  assign HREADYOUTS = pend ? 1'b0 : (dphase_active ? readyout_dec : 1'b1);
  assign HRESPS     = dphase_active ? resp_dec : RESP_OKAY;

endmodule

// File: tb/tb_ahb_bm_input_stage.sv
// Bench for ahb_bm_input_stage: table of per-cycle vectors, reset corner sequence, and a model-driven random run.
module tb_ahb_bm_input_stage;
  import ahb_bm_input_stage_pkg::*;

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
    logic        ready;
    logic        accept;
    logic        dph;
    logic        rdy_dec;
    logic        resp_dec;
  } in_t;

  typedef struct packed {
    logic        readyout;
    logic        resp;
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
    logic        held;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS, HWRITES, HMASTLOCKS, HREADYS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS;
  logic        addr_accept, dphase_active, readyout_dec, resp_dec;
  logic        HREADYOUTS, HRESPS, sel_out, write_out, mastlock_out, held_tran;
  logic [31:0] addr_out;
  logic [1:0]  trans_out;
  logic [2:0]  size_out, burst_out;
  logic [3:0]  prot_out;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  out_t exp_q[$];

  logic m_pend;
  in_t  m_hold;

  always #5 HCLK = ~HCLK;

  ahb_bm_input_stage #(.ADDR_W(32), .PROT_W(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_out(sel_out),
    .addr_out(addr_out), .trans_out(trans_out), .write_out(write_out),
    .size_out(size_out), .burst_out(burst_out), .prot_out(prot_out),
    .mastlock_out(mastlock_out), .held_tran(held_tran),
    .addr_accept(addr_accept), .dphase_active(dphase_active),
    .readyout_dec(readyout_dec), .resp_dec(resp_dec)
  );

  function automatic in_t mi(input logic [31:0] sel, addr, trans, write, size, burst, prot,
                             lock, ready, accept, dph, rdy, resp);
    in_t i;
    i.sel = sel[0]; i.addr = addr; i.trans = trans[1:0]; i.write = write[0];
    i.size = size[2:0]; i.burst = burst[2:0]; i.prot = prot[3:0]; i.lock = lock[0];
    i.ready = ready[0]; i.accept = accept[0]; i.dph = dph[0];
    i.rdy_dec = rdy[0]; i.resp_dec = resp[0];
    return i;
  endfunction

  function automatic out_t mo(input logic [31:0] rdyo, resp, sel, addr, trans, write, size,
                              burst, prot, lock, held);
    out_t o;
    o.readyout = rdyo[0]; o.resp = resp[0]; o.sel = sel[0]; o.addr = addr;
    o.trans = trans[1:0]; o.write = write[0]; o.size = size[2:0]; o.burst = burst[2:0];
    o.prot = prot[3:0]; o.lock = lock[0]; o.held = held[0];
    return o;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t i);
    HSELS = i.sel; HADDRS = i.addr; HTRANSS = i.trans; HWRITES = i.write;
    HSIZES = i.size; HBURSTS = i.burst; HPROTS = i.prot; HMASTLOCKS = i.lock;
    HREADYS = i.ready; addr_accept = i.accept; dphase_active = i.dph;
    readyout_dec = i.rdy_dec; resp_dec = i.resp_dec;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int tag);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, tag, act, exp);
    end
  endtask

  task automatic cmp(input out_t e, input int tag);
    chk("HREADYOUTS",   32'(HREADYOUTS),   32'(e.readyout), tag);
    chk("HRESPS",       32'(HRESPS),       32'(e.resp),     tag);
    chk("sel_out",      32'(sel_out),      32'(e.sel),      tag);
    chk("addr_out",     addr_out,          e.addr,          tag);
    chk("trans_out",    32'(trans_out),    32'(e.trans),    tag);
    chk("write_out",    32'(write_out),    32'(e.write),    tag);
    chk("size_out",     32'(size_out),     32'(e.size),     tag);
    chk("burst_out",    32'(burst_out),    32'(e.burst),    tag);
    chk("prot_out",     32'(prot_out),     32'(e.prot),     tag);
    chk("mastlock_out", 32'(mastlock_out), 32'(e.lock),     tag);
    chk("held_tran",    32'(held_tran),    32'(e.held),     tag);
  endtask

  // Behavioural reference used for the random run.
  function automatic out_t model(input in_t i);
    out_t o;
    o.readyout = m_pend ? 1'b0 : (i.dph ? i.rdy_dec : 1'b1);
    o.resp     = i.dph ? i.resp_dec : 1'b0;
    o.held     = m_pend;
    if (m_pend) begin
      o.sel = 1'b1; o.addr = m_hold.addr; o.write = m_hold.write; o.size = m_hold.size;
      o.prot = m_hold.prot; o.lock = m_hold.lock;
      o.trans = (m_hold.trans == 2'b11) ? 2'b10 : m_hold.trans;
      o.burst = (m_hold.trans == 2'b11) ? 3'b001 : m_hold.burst;
    end else begin
      o.sel = i.sel & i.ready; o.addr = i.addr; o.write = i.write; o.size = i.size;
      o.prot = i.prot; o.lock = i.lock; o.trans = i.trans; o.burst = i.burst;
    end
    return o;
  endfunction

  initial begin
    in_t  cur;
    out_t e;

    drive(mi(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    HRESETn = 1'b0;
    #1;
    chk("reset HREADYOUTS", 32'(HREADYOUTS), 32'd1, 0);
    chk("reset HRESPS",     32'(HRESPS),     32'd0, 0);
    chk("reset sel_out",    32'(sel_out),    32'd1, 0);
    chk("reset held_tran",  32'(held_tran),  32'd0, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Granted in the same cycle, then data phase waits once.
    add(mi(1, 'h2000_0010, 2, 1, 2, 0, 3, 0, 1, 1, 0, 0, 0), mo(1, 0, 1, 'h2000_0010, 2, 1, 2, 0, 3, 0, 0));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),          mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0),          mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Held read: three stalled cycles with changing inputs.
    add(mi(1, 'h4000_0000, 2, 0, 2, 0, 1, 0, 1, 0, 0, 0, 0), mo(1, 0, 1, 'h4000_0000, 2, 0, 2, 0, 1, 0, 0));
    add(mi(1, 'h1234_5678, 0, 1, 1, 5, 15, 1, 0, 0, 0, 0, 0), mo(0, 0, 1, 'h4000_0000, 2, 0, 2, 0, 1, 0, 1));
    add(mi(1, 'h1234_5678, 0, 1, 1, 5, 15, 1, 0, 0, 0, 0, 0), mo(0, 0, 1, 'h4000_0000, 2, 0, 2, 0, 1, 0, 1));
    add(mi(1, 'h1234_5678, 0, 1, 1, 5, 15, 1, 0, 1, 0, 0, 0), mo(0, 0, 1, 'h4000_0000, 2, 0, 2, 0, 1, 0, 1));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0),          mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Held SEQ INCR4 reissued as NONSEQ INCR.
    add(mi(1, 'h3000_0004, 3, 1, 2, 3, 2, 0, 1, 0, 0, 0, 0), mo(1, 0, 1, 'h3000_0004, 3, 1, 2, 3, 2, 0, 0));
    add(mi(1, 'h3000_0008, 3, 1, 2, 3, 2, 0, 0, 1, 0, 0, 0), mo(0, 0, 1, 'h3000_0004, 2, 1, 2, 1, 2, 0, 1));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0),          mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Two-cycle ERROR, with a transfer captured in the second cycle.
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1),          mo(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mi(1, 'h5000_0000, 2, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1), mo(1, 1, 1, 'h5000_0000, 2, 0, 0, 0, 0, 0, 0));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0),          mo(0, 0, 1, 'h5000_0000, 2, 0, 0, 0, 0, 0, 1));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0),          mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Locked NONSEQ held with its lock; then IDLE/BUSY never captured.
    add(mi(1, 'h6000_0000, 2, 1, 2, 5, 0, 1, 1, 0, 0, 0, 0), mo(1, 0, 1, 'h6000_0000, 2, 1, 2, 5, 0, 1, 0));
    add(mi(1, 'h6000_0004, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 1, 'h6000_0000, 2, 1, 2, 5, 0, 1, 1));
    add(mi(1, 'h6000_0004, 3, 1, 2, 1, 0, 0, 0, 1, 0, 0, 0), mo(0, 0, 1, 'h6000_0000, 2, 1, 2, 5, 0, 1, 1));
    add(mi(1, 'h7000_0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), mo(1, 0, 1, 'h7000_0000, 0, 0, 0, 0, 0, 0, 0));
    add(mi(1, 'h7000_0000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), mo(1, 0, 1, 'h7000_0000, 0, 0, 0, 0, 0, 0, 0));
    add(mi(1, 'h7000_0004, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), mo(1, 0, 1, 'h7000_0004, 1, 0, 0, 0, 0, 0, 0));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0),          mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      @(negedge HCLK);
      drive(vecs[k].i);
      exp_q.push_back(vecs[k].o);
      #1;
      cmp(exp_q.pop_front(), k + 1);
    end

    // Asynchronous reset while a transfer is held.
    @(negedge HCLK);
    drive(mi(1, 'h8000_0000, 2, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0));
    @(negedge HCLK);
    drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre-reset held_tran", 32'(held_tran), 32'd1, 100);
    chk("pre-reset addr_out",  addr_out, 32'h8000_0000, 100);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("async reset held_tran",  32'(held_tran),  32'd0, 101);
    chk("async reset HREADYOUTS", 32'(HREADYOUTS), 32'd1, 101);
    chk("async reset sel_out",    32'(sel_out),    32'd0, 101);
    @(negedge HCLK);
    HRESETn = 1'b1;
    drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    @(negedge HCLK);
    #1;
    chk("post-reset held_tran", 32'(held_tran), 32'd0, 102);
    chk("post-reset sel_out",   32'(sel_out),   32'd0, 102);
    chk("post-reset addr_out",  addr_out,       32'd0, 102);

    // Random traffic against the reference model; HREADYS follows the expected HREADYOUTS.
    m_pend = 1'b0;
    m_hold = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge HCLK);
      cur.sel      = 1'($urandom_range(0, 3) != 0);
      cur.addr     = $urandom();
      cur.trans    = 2'($urandom_range(0, 3));
      cur.write    = 1'($urandom_range(0, 1));
      cur.size     = 3'($urandom_range(0, 2));
      cur.burst    = 3'($urandom_range(0, 7));
      cur.prot     = 4'($urandom_range(0, 15));
      cur.lock     = 1'($urandom_range(0, 1));
      cur.accept   = 1'($urandom_range(0, 2) == 0);
      cur.dph      = m_pend ? 1'b0 : 1'($urandom_range(0, 1));
      cur.rdy_dec  = 1'($urandom_range(0, 3) != 0);
      cur.resp_dec = 1'($urandom_range(0, 4) == 0);
      cur.ready    = m_pend ? 1'b0 : (cur.dph ? cur.rdy_dec : 1'b1);
      drive(cur);
      exp_q.push_back(model(cur));
      #1;
      e = exp_q.pop_front();
      cmp(e, 1000 + n);
      if (!m_pend && cur.sel && cur.ready && cur.trans[1] && !cur.accept) begin
        m_pend = 1'b1;
        m_hold = cur;
      end else if (m_pend && cur.accept) begin
        m_pend = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_bm_input_stage.md
Name: ahb_bm_input_stage

Overview:
Master-side input stage of the sparse-connectivity AHB bus matrix, one instance per master port. It is the initiator-facing counterpart of the per-slave output arbiters.
- Presents the master's address phase towards the decoder/arbiters.
- Captures and holds that address phase when the target output port does not grant it in the same cycle.
- Stalls the master via HREADYOUTS until the held transfer is accepted.
- Returns data-phase ready/response back to the master.

Parameters:
ADDR_W, 32, address width
PROT_W, 4, HPROT width

Ports:
HCLK  in  1  AHB system clock
HRESETn  in  1  reset, asynchronous, active-low
HSELS  in  1  master-side select
HADDRS  in  ADDR_W  master address
HTRANSS  in  2  transfer type
HWRITES  in  1  write flag
HSIZES  in  3  transfer size
HBURSTS  in  3  burst type
HPROTS  in  PROT_W  protection
HMASTLOCKS  in  1  locked transfer
HREADYS  in  1  layer HREADY (address phase valid when high)
HREADYOUTS  out  1  ready returned to master
HRESPS  out  1  response returned to master (0=OKAY, 1=ERROR)
sel_out  out  1  address phase presented to decoder
addr_out  out  ADDR_W  presented address
trans_out  out  2  presented HTRANS
write_out, size_out(3), burst_out(3), prot_out(PROT_W), mastlock_out  out  presented control
held_tran  out  1  hold register occupied
addr_accept  in  1  selected output arbiter granted this port AND HREADYM high this cycle
dphase_active  in  1  a data phase for this port is in progress at an output port
readyout_dec  in  1  slave HREADYOUT routed back by decoder
resp_dec  in  1  slave HRESP routed back by decoder

Behaviour:
- new_tran = HSELS & HREADYS & HTRANSS[1] (NONSEQ or SEQ).
- State pend (held_tran), 1 bit. Hold registers: addr, trans, write, size, burst, prot, mastlock.
- Capture when pend=0 & new_tran & !addr_accept.
  - Next cycle pend=1; all HxxxS fields are registered.
- Pass-through when pend=0 & new_tran & addr_accept.
  - No capture; pend stays 0.
- Release when pend=1 & addr_accept.
  - Next cycle pend=0.
  - new_tran cannot occur while pend=1, because HREADYOUTS=0 and HREADYS follows it.
- Output mux:
  - pend=1: outputs come from the hold registers; sel_out=1.
  - pend=0: outputs come from the live inputs; sel_out = HSELS & HREADYS.
- SEQ conversion: a held SEQ is presented as trans_out=NONSEQ and burst_out=INCR (3'b001), because arbitration may have broken the burst. A held NONSEQ is presented unchanged.
- HREADYOUTS:
  - pend=1 -> 0.
  - else dphase_active -> readyout_dec.
  - else 1.
- HRESPS: dphase_active ? resp_dec : 0.
  - Two-cycle ERROR passes through unmodified.
  - A transfer captured during the second ERROR cycle is still held and issued normally; it is not cancelled.
- Latency:
  - Granted immediately: zero added cycles.
  - Held: ≥1 wait state. HREADYOUTS low from the cycle after capture through the acceptance cycle; data phase starts the cycle after addr_accept.
- Lock: mastlock_out is held with the transfer. Held locked transfers are never dropped.
- IDLE/BUSY transfers: never captured; passed through live when pend=0.
- addr_accept when pend=0 and no new_tran: ignored.
- Reset: pend=0, all hold registers 0.
  - Outputs at reset: HREADYOUTS=1, HRESPS=0, sel_out=HSELS&HREADYS, held_tran=0.
  - Reset mid-hold discards the held transfer.

Decomposition:
- Shared package: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HBURST encodings, HRESP OKAY/ERROR.
  - The output arbiters and the decoder use the same package.
- No sub-module needed. The hold bank plus 1-bit pend plus output mux fits in one module of about 150 lines.

Test Plan:
- NONSEQ write addr 0x2000_0010, addr_accept=1 same cycle -> held_tran stays 0, addr_out=0x2000_0010, HREADYOUTS=1, next-cycle data phase follows readyout_dec.
- NONSEQ read addr 0x4000_0000, addr_accept=0 for 3 cycles, then 1 -> held_tran=1 for 3 cycles, HREADYOUTS=0 for those 3 cycles, addr_out stable at 0x4000_0000 while inputs change, held_tran=0 after accept.
- SEQ INCR4 beat held -> trans_out=2'b10, burst_out=3'b001; original HTRANSS/HBURSTS ignored while held.
- dphase_active=1, readyout_dec=0 then 1 with resp_dec=1 for 2 cycles -> HREADYOUTS 0,1 mirrored; HRESPS=1 for both cycles.
- HRESETn asserted asynchronously while held_tran=1 -> held_tran=0, HREADYOUTS=1 immediately; after release, no stale transfer presented (sel_out=0 with HSELS=0).
- Locked NONSEQ held with HMASTLOCKS=1 -> mastlock_out=1 throughout the hold; IDLE transfer with HSELS=1 -> never captured, trans_out=2'b00 passed live.
